// File: rtl/lifo_arbiter.sv
// Round-robin arbiter sharing one LIFO among N_REQ requesters.
// Grants at most one push or pop per cycle, drives the LIFO control
// and returns pop data tagged with the requester index one cycle later.
module lifo_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int N_REQ      = 4,
  parameter int ID_W       = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_pop,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_grant,
  output logic                        lifo_wen,
  output logic                        lifo_ren,
  output logic [DATA_WIDTH-1:0]       lifo_data_in,
  input  logic                        lifo_full,
  input  logic                        lifo_empty,
  input  logic [DATA_WIDTH-1:0]       lifo_data_out,
  output logic                        rsp_valid,
  output logic [ID_W-1:0]             rsp_id,
  output logic [DATA_WIDTH-1:0]       rsp_data,
  output logic                        busy
);

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  win_idx;
  logic [N_REQ-1:0] elig;
  logic [ID_W:0]    pos;
  logic             found;
  logic             issue_push;
  logic             issue_pop;

  // Eligibility: a request can only be served if the LIFO can take it now.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      elig[i] = req_valid[i] & (req_pop[i] ? ~lifo_empty : ~lifo_full);
    end
  end

  // Round-robin search starting at rr_ptr; the modulo wrap is done with one
  // conditional subtract on a one-bit-wider sum, so no divider is needed.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    pos     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (pos >= (ID_W+1)'(N_REQ)) begin
        pos = pos - (ID_W+1)'(N_REQ);
      end
      if (!found && elig[pos[ID_W-1:0]]) begin
        found   = 1'b1;
        win_idx = pos[ID_W-1:0];
      end
    end
  end

  // One-hot grant, suppressed while reset is held.
  always_comb begin
    req_grant = '0;
    if (found && !reset) begin
      req_grant[win_idx] = 1'b1;
    end
  end

  // Issue decode: the single granted op becomes either a write or a read.
  always_comb begin
    issue_pop    = |(req_grant & req_pop);
    issue_push   = |(req_grant & ~req_pop);
    lifo_wen     = issue_push;
    lifo_ren     = issue_pop;
    lifo_data_in = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_grant[i] && !req_pop[i]) begin
        lifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Pointer advance, pop-response tagging and activity flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      busy      <= 1'b0;
    end else begin
      busy      <= |req_valid;
      rsp_valid <= issue_pop;
      if (issue_pop) begin
        rsp_id <= win_idx;
      end
      if (found) begin
        rr_ptr <= (win_idx == ID_W'(N_REQ-1)) ? '0 : win_idx + ID_W'(1);
      end
    end
  end

  // LIFO read data is only meaningful in the cycle after a granted pop.
  always_comb begin
    rsp_data = rsp_valid ? lifo_data_out : '0;
  end

  ap_grant_onehot: assert property (@(posedge clk) $onehot0(req_grant));
  ap_grant_elig:   assert property (@(posedge clk) (req_grant & ~elig) == '0);
  ap_wen_not_full: assert property (@(posedge clk) lifo_wen |-> !lifo_full);
  ap_ren_not_empty: assert property (@(posedge clk) lifo_ren |-> !lifo_empty);
  ap_not_both:     assert property (@(posedge clk) !(lifo_wen && lifo_ren));

endmodule

// File: tb/tb_lifo_arbiter.sv
// Directed bench for lifo_arbiter with N_REQ=3, DATA_WIDTH=8 and a
// four-entry behavioural LIFO attached.
module tb_lifo_arbiter;
  localparam int N  = 3;
  localparam int DW = 8;

  logic          clk;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_pop;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_grant;
  logic          lifo_wen;
  logic          lifo_ren;
  logic [DW-1:0] lifo_data_in;
  logic          lifo_full;
  logic          lifo_empty;
  logic [DW-1:0] lifo_data_out;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [DW-1:0] rsp_data;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  lifo_arbiter #(.DATA_WIDTH(DW), .N_REQ(N)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_pop(req_pop), .req_data(req_data),
    .req_grant(req_grant),
    .lifo_wen(lifo_wen), .lifo_ren(lifo_ren), .lifo_data_in(lifo_data_in),
    .lifo_full(lifo_full), .lifo_empty(lifo_empty), .lifo_data_out(lifo_data_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 4-entry LIFO; model_drain discards pushes, model_clr empties it.
  logic [DW-1:0] mem [4];
  logic [2:0]    cnt;
  logic [DW-1:0] m_dout;
  logic          model_clr;
  logic          model_drain;
  logic [1:0]    top;

  assign top           = cnt[1:0] - 2'd1;
  assign lifo_full     = (cnt == 3'd4);
  assign lifo_empty    = (cnt == 3'd0);
  assign lifo_data_out = m_dout;

  always_ff @(posedge clk) begin
    if (model_clr) begin
      cnt <= 3'd0;
    end else if (lifo_ren && cnt != 3'd0) begin
      m_dout <= mem[top];
      cnt    <= cnt - 3'd1;
    end else if (lifo_wen && cnt != 3'd4 && !model_drain) begin
      mem[cnt[1:0]] <= lifo_data_in;
      cnt           <= cnt + 3'd1;
    end
  end

  logic [12:0] iss;
  logic [10:0] rsp;
  assign iss = {req_grant, lifo_wen, lifo_ren, lifo_data_in};
  assign rsp = {rsp_valid, rsp_id, rsp_data};

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; model_clr = 1'b1; model_drain = 1'b0;
    req_valid = '0; req_pop = '0; req_data = '0;
    next_cycle; next_cycle;
    req_valid = 3'b001; req_data = {8'h00, 8'h00, 8'h77};
    #2;
    n_checks++;
    if (iss !== {3'b000, 1'b0, 1'b0, 8'h00}) begin
      n_fail++; $display("FAIL reset_forces_idle: got %h want %h", iss, 13'h0);
    end
    next_cycle;
    req_valid = '0;
    next_cycle;
    reset = 1'b0; model_clr = 1'b0;
    #2;
    n_checks++;
    if ({iss, rsp, busy} !== '0) begin
      n_fail++; $display("FAIL reset_idle_state: iss=%h rsp=%h busy=%b want all 0", iss, rsp, busy);
    end
  endtask

  task automatic test_push_rr;
    next_cycle;
    req_valid = 3'b111; req_pop = 3'b000; req_data = {8'h33, 8'h22, 8'h11};
    #2;
    n_checks++;
    if (iss !== {3'b001, 1'b1, 1'b0, 8'h11}) begin
      n_fail++; $display("FAIL push_grant0: got %h want %h", iss, {3'b001, 1'b1, 1'b0, 8'h11});
    end
    next_cycle;
    req_valid = 3'b110;
    #2;
    n_checks++;
    if (iss !== {3'b010, 1'b1, 1'b0, 8'h22}) begin
      n_fail++; $display("FAIL push_grant1: got %h want %h", iss, {3'b010, 1'b1, 1'b0, 8'h22});
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_set: got %b want 1", busy);
    end
    next_cycle;
    req_valid = 3'b100;
    #2;
    n_checks++;
    if (iss !== {3'b100, 1'b1, 1'b0, 8'h33}) begin
      n_fail++; $display("FAIL push_grant2: got %h want %h", iss, {3'b100, 1'b1, 1'b0, 8'h33});
    end
    next_cycle;
    req_valid = '0;
    #2;
    n_checks++;
    if ({cnt, mem[0], mem[1], mem[2]} !== {3'd3, 8'h11, 8'h22, 8'h33}) begin
      n_fail++; $display("FAIL push_contents: got cnt=%0d %h %h %h want 3 11 22 33", cnt, mem[0], mem[1], mem[2]);
    end
  endtask

  task automatic test_pop_rsp;
    next_cycle;
    req_valid = 3'b100; req_pop = 3'b100;
    #2;
    n_checks++;
    if (iss !== {3'b100, 1'b0, 1'b1, 8'h00}) begin
      n_fail++; $display("FAIL pop2_issue: got %h want %h", iss, {3'b100, 1'b0, 1'b1, 8'h00});
    end
    next_cycle;
    req_valid = 3'b001; req_pop = 3'b001;
    #2;
    n_checks++;
    if (rsp !== {1'b1, 2'd2, 8'h33}) begin
      n_fail++; $display("FAIL pop2_rsp: got %h want %h", rsp, {1'b1, 2'd2, 8'h33});
    end
    n_checks++;
    if (iss !== {3'b001, 1'b0, 1'b1, 8'h00}) begin
      n_fail++; $display("FAIL pop0_issue: got %h want %h", iss, {3'b001, 1'b0, 1'b1, 8'h00});
    end
    next_cycle;
    req_valid = '0; req_pop = '0;
    #2;
    n_checks++;
    if (rsp !== {1'b1, 2'd0, 8'h22}) begin
      n_fail++; $display("FAIL pop0_rsp: got %h want %h", rsp, {1'b1, 2'd0, 8'h22});
    end
    next_cycle;
    #2;
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rsp_clears: got %b want 0", rsp_valid);
    end
  endtask

  task automatic test_reset_mid_pop;
    next_cycle;
    reset = 1'b1; req_valid = 3'b010; req_pop = 3'b010;
    #2;
    n_checks++;
    if (iss !== 13'h0) begin
      n_fail++; $display("FAIL midpop_issue: got %h want 0", iss);
    end
    next_cycle;
    reset = 1'b0; req_valid = '0; req_pop = '0;
    #2;
    n_checks++;
    if ({rsp_valid, cnt} !== {1'b0, 3'd1}) begin
      n_fail++; $display("FAIL midpop_rsp: got valid=%b cnt=%0d want 0 1", rsp_valid, cnt);
    end
  endtask

  task automatic test_full;
    next_cycle;
    req_valid = 3'b001; req_pop = 3'b000; req_data = {8'h00, 8'h00, 8'h44};
    for (int i = 0; i < 3; i++) begin
      #2;
      n_checks++;
      if (iss !== {3'b001, 1'b1, 1'b0, 8'h44}) begin
        n_fail++; $display("FAIL fill_push%0d: got %h want %h", i, iss, {3'b001, 1'b1, 1'b0, 8'h44});
      end
      next_cycle;
    end
    req_valid = 3'b011; req_pop = 3'b010;
    #2;
    n_checks++;
    if (iss !== {3'b010, 1'b0, 1'b1, 8'h00}) begin
      n_fail++; $display("FAIL full_pop_only: got %h want %h", iss, {3'b010, 1'b0, 1'b1, 8'h00});
    end
    next_cycle;
    req_valid = 3'b001; req_pop = 3'b000;
    #2;
    n_checks++;
    if (iss !== {3'b001, 1'b1, 1'b0, 8'h44}) begin
      n_fail++; $display("FAIL push_after_full: got %h want %h", iss, {3'b001, 1'b1, 1'b0, 8'h44});
    end
    n_checks++;
    if (rsp !== {1'b1, 2'd1, 8'h44}) begin
      n_fail++; $display("FAIL full_pop_rsp: got %h want %h", rsp, {1'b1, 2'd1, 8'h44});
    end
    next_cycle;
    #2;
    n_checks++;
    if ({cnt, iss} !== {3'd4, 13'h0}) begin
      n_fail++; $display("FAIL full_push_stall: got cnt=%0d iss=%h want 4 0", cnt, iss);
    end
    next_cycle;
    req_valid = '0;
  endtask

  task automatic test_empty;
    model_clr = 1'b1;
    next_cycle;
    model_clr = 1'b0;
    req_valid = 3'b110; req_pop = 3'b010; req_data = {8'hA5, 8'h00, 8'h00};
    #2;
    n_checks++;
    if (iss !== {3'b100, 1'b1, 1'b0, 8'hA5}) begin
      n_fail++; $display("FAIL empty_push_first: got %h want %h", iss, {3'b100, 1'b1, 1'b0, 8'hA5});
    end
    next_cycle;
    req_valid = 3'b010;
    #2;
    n_checks++;
    if (iss !== {3'b010, 1'b0, 1'b1, 8'h00}) begin
      n_fail++; $display("FAIL empty_pop_next: got %h want %h", iss, {3'b010, 1'b0, 1'b1, 8'h00});
    end
    next_cycle;
    req_valid = '0; req_pop = '0;
    #2;
    n_checks++;
    if (rsp !== {1'b1, 2'd1, 8'hA5}) begin
      n_fail++; $display("FAIL empty_pop_rsp: got %h want %h", rsp, {1'b1, 2'd1, 8'hA5});
    end
  endtask

  task automatic test_alternate;
    next_cycle;
    req_valid = 3'b001; req_pop = 3'b000; req_data = {8'h00, 8'h00, 8'h5A};
    #2;
    n_checks++;
    if (iss !== {3'b001, 1'b1, 1'b0, 8'h5A}) begin
      n_fail++; $display("FAIL alt_push1: got %h want %h", iss, {3'b001, 1'b1, 1'b0, 8'h5A});
    end
    next_cycle;
    req_pop = 3'b001;
    #2;
    n_checks++;
    if (iss !== {3'b001, 1'b0, 1'b1, 8'h00}) begin
      n_fail++; $display("FAIL alt_pop1: got %h want %h", iss, {3'b001, 1'b0, 1'b1, 8'h00});
    end
    next_cycle;
    req_pop = 3'b000; req_data = {8'h00, 8'h00, 8'h5B};
    #2;
    n_checks++;
    if ({iss, rsp} !== {3'b001, 1'b1, 1'b0, 8'h5B, 1'b1, 2'd0, 8'h5A}) begin
      n_fail++; $display("FAIL alt_push2: got %h want %h", {iss, rsp}, {3'b001, 1'b1, 1'b0, 8'h5B, 1'b1, 2'd0, 8'h5A});
    end
    next_cycle;
    req_pop = 3'b001;
    #2;
    n_checks++;
    if (iss !== {3'b001, 1'b0, 1'b1, 8'h00}) begin
      n_fail++; $display("FAIL alt_pop2: got %h want %h", iss, {3'b001, 1'b0, 1'b1, 8'h00});
    end
    next_cycle;
    req_valid = '0; req_pop = '0;
    #2;
    n_checks++;
    if (rsp !== {1'b1, 2'd0, 8'h5B}) begin
      n_fail++; $display("FAIL alt_rsp2: got %h want %h", rsp, {1'b1, 2'd0, 8'h5B});
    end
  endtask

  task automatic test_fairness;
    logic [2:0] exp_seq [9];
    exp_seq = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
    next_cycle;
    model_drain = 1'b1;
    req_valid = 3'b111; req_pop = 3'b000; req_data = {8'hC3, 8'hC2, 8'hC1};
    for (int i = 0; i < 9; i++) begin
      #2;
      n_checks++;
      if (req_grant !== exp_seq[i]) begin
        n_fail++; $display("FAIL rr_seq%0d: got %b want %b", i, req_grant, exp_seq[i]);
      end
      next_cycle;
    end
    req_valid = '0;
    #2;
    n_checks++;
    if ({busy, cnt} !== {1'b1, 3'd0}) begin
      n_fail++; $display("FAIL rr_busy_hold: got busy=%b cnt=%0d want 1 0", busy, cnt);
    end
    next_cycle;
    model_drain = 1'b0;
    #2;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_clear: got %b want 0", busy);
    end
  endtask

  initial begin
    test_reset;
    test_push_rr;
    test_pop_rsp;
    test_reset_mid_pop;
    test_full;
    test_empty;
    test_alternate;
    test_fairness;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lifo_arbiter.md
Name: lifo_arbiter

Overview:
- Round-robin arbiter that shares one lifo instance among N_REQ requesters.
- Each requester posts a push or a pop. The arbiter grants at most one operation per cycle and drives the LIFO's wen/ren/data_in.
- Pop data is returned to the winning requester with a requester tag, one cycle after issue.
- Sits between client blocks and the LIFO storage. Owns all LIFO control.

Parameters:
- DATA_WIDTH, 8, width of push/pop data (must match the attached LIFO).
- N_REQ, 4, number of requesters (>=2).
- ID_W, $clog2(N_REQ), width of the requester index / response tag.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request pending; held until granted.
- req_pop  in  N_REQ  per-requester op type: 1 = pop, 0 = push.
- req_data  in  N_REQ*DATA_WIDTH  push data; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_grant  out  N_REQ  one-hot (or zero) grant; combinational, same cycle as issue.
- lifo_wen  out  1  LIFO write enable.
- lifo_ren  out  1  LIFO read enable.
- lifo_data_in  out  DATA_WIDTH  push data to the LIFO.
- lifo_full  in  1  LIFO full flag.
- lifo_empty  in  1  LIFO empty flag.
- lifo_data_out  in  DATA_WIDTH  LIFO read data, valid the cycle after ren.
- rsp_valid  out  1  pop response valid (registered).
- rsp_id  out  ID_W  requester index of the pop being returned.
- rsp_data  out  DATA_WIDTH  popped data; passes lifo_data_out through while rsp_valid=1.
- busy  out  1  registered; 1 when any req_valid was asserted in the previous cycle.

Behaviour:
- Reset (sync, clk edge with reset=1):
  - rr_ptr=0; rsp_valid=0; rsp_id=0; busy=0.
  - req_grant/lifo_wen/lifo_ren are forced 0 while reset=1.
  - Reset mid-operation drops any pending response. Requesters must re-post.
- Eligibility, per cycle, for requester i:
  - elig[i] = req_valid[i] & (req_pop[i] ? !lifo_empty : !lifo_full).
  - Ineligible requests wait; they are never dropped or errored.
- Arbitration:
  - Search starts at rr_ptr and wraps modulo N_REQ. The first eligible i wins.
  - No eligible requester: grant=0 and rr_ptr holds.
- Issue, in the same cycle as the grant:
  - req_grant[i]=1.
  - Push: lifo_wen=1 and lifo_data_in = req_data slice i. Pop: lifo_ren=1.
  - lifo_wen and lifo_ren are never both 1.
  - lifo_data_in = 0 when not pushing.
- Pointer update: at the clk edge after a grant to i, rr_ptr <= (i+1) mod N_REQ.
- Requester handshake: the requester sees req_grant[i]=1 and may change or drop its request on the next cycle.
- Pop response:
  - rsp_valid is registered. If a pop was granted to i in cycle T, then in cycle T+1: rsp_valid=1, rsp_id=i, rsp_data=lifo_data_out.
  - Otherwise rsp_valid=0.
  - Latency is exactly 1 cycle, with no backpressure on the response.
- Throughput: one operation per cycle.
  - Back-to-back push/pop from different requesters is allowed.
  - LIFO flags update at the same edge as the operation, so the next cycle's eligibility sees the new occupancy.
- Boundaries:
  - Full: pushes stall and pops still proceed. Empty: pops stall and pushes still proceed.
  - Full with only pushers pending: no grant, no deadlock requirement on the arbiter (client responsibility).
  - Single requester alternating push/pop: served every cycle.
- Invariants (for assertions):
  - $onehot0(req_grant).
  - req_grant[i] implies elig[i].
  - lifo_wen implies !lifo_full; lifo_ren implies !lifo_empty.

Test Plan (N_REQ=3, DATA_WIDTH=8, LIFO BUFFER_NO=4):
1. Reset, then idle → req_grant=0, lifo_wen=lifo_ren=0, rsp_valid=0, busy=0. Assert reset mid-pop → rsp_valid=0 next cycle.
2. Requesters 0, 1, 2 all push (0x11, 0x22, 0x33) continuously from rr_ptr=0 → grants 0,1,2 on consecutive cycles; LIFO holds 0x11, 0x22, 0x33.
3. With 3 entries, requester 2 pops → rsp_valid=1, rsp_id=2, rsp_data=0x33 exactly one cycle after its grant. Next pop by requester 0 → 0x22.
4. Fill the LIFO (full=1), then req 0 pushes and req 1 pops → req 0 never granted while full. Req 1 is granted; req 0 is granted the cycle after full drops.
5. Empty LIFO, req 1 pops and req 2 pushes 0xA5 → req 2 granted first. Req 1 granted next cycle; response rsp_id=1, rsp_data=0xA5.
6. All three requesters hold pushes for 9 cycles with the LIFO drained externally → grant sequence strictly 0,1,2,0,1,2,…; no requester starves.
